// File: rtl/axi_eth_tx_ctrl_bridge.sv
// TX front end for the AXI Ethernet MAC: emits a control stream on m_axis_txc
// ahead of every frame, then forwards the frame from s_axis_txd to m_axis_txd.
// TX status is always accepted and summarised in counters.
module axi_eth_tx_ctrl_bridge #(
   parameter int unsigned C_TDATA_WIDTH = 32,
   parameter int unsigned C_CTRL_WORDS  = 6,
   parameter int unsigned C_CSUM_EN     = 0,
   parameter int unsigned C_CNT_WIDTH   = 16
) (
   input  logic                       aclk,
   input  logic                       areset,
   input  logic                       enable,
   input  logic [1:0]                 cfg_csum_ctrl,
   input  logic [15:0]                cfg_csum_begin,
   input  logic [15:0]                cfg_csum_insert,
   input  logic [15:0]                cfg_csum_init,
   input  logic [C_TDATA_WIDTH-1:0]   s_axis_txd_tdata,
   input  logic [C_TDATA_WIDTH/8-1:0] s_axis_txd_tkeep,
   input  logic                       s_axis_txd_tlast,
   input  logic                       s_axis_txd_tvalid,
   output logic                       s_axis_txd_tready,
   output logic [C_TDATA_WIDTH-1:0]   m_axis_txd_tdata,
   output logic [C_TDATA_WIDTH/8-1:0] m_axis_txd_tkeep,
   output logic                       m_axis_txd_tlast,
   output logic                       m_axis_txd_tvalid,
   input  logic                       m_axis_txd_tready,
   output logic [31:0]                m_axis_txc_tdata,
   output logic [3:0]                 m_axis_txc_tkeep,
   output logic                       m_axis_txc_tlast,
   output logic                       m_axis_txc_tvalid,
   input  logic                       m_axis_txc_tready,
   input  logic [31:0]                s_axis_txs_tdata,
   input  logic [3:0]                 s_axis_txs_tkeep,
   input  logic                       s_axis_txs_tlast,
   input  logic                       s_axis_txs_tvalid,
   output logic                       s_axis_txs_tready,
   output logic [C_CNT_WIDTH-1:0]     frame_cnt,
   output logic [C_CNT_WIDTH-1:0]     status_cnt,
   output logic [31:0]                status_last,
   output logic                       busy
);

   localparam int unsigned IDX_W    = 4;
   localparam int unsigned LAST_IDX = C_CTRL_WORDS - 1;
   localparam logic [31:0] WORD0    = 32'hA000_0000;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_CTRL = 2'd1,
      ST_DATA = 2'd2
   } state_t;

   state_t                 state_q;
   logic [IDX_W-1:0]       idx_q;
   logic [IDX_W-1:0]       idx_d;
   logic [1:0]             csum_ctrl_q;
   logic [15:0]            csum_begin_q;
   logic [15:0]            csum_insert_q;
   logic [15:0]            csum_init_q;
   logic                   txc_valid_q;
   logic                   txc_last_q;
   logic [31:0]            txc_data_q;
   logic [C_CNT_WIDTH-1:0] frame_cnt_q;
   logic [C_CNT_WIDTH-1:0] status_cnt_q;
   logic [31:0]            status_last_q;
   logic                   in_data;
   logic                   txd_last_hs;
   logic                   unused_txs_keep;

   // Control word contents for beat i, built from the per-frame shadow copy
   function automatic logic [31:0] ctrl_word(input logic [IDX_W-1:0] i,
                                             input logic [1:0]       c_ctrl,
                                             input logic [15:0]      c_begin,
                                             input logic [15:0]      c_insert,
                                             input logic [15:0]      c_init);
      logic [31:0] w;
      w = 32'h0;
      if (i == IDX_W'(0)) begin
         w = WORD0;
      end else if (C_CSUM_EN != 0) begin
         case (i)
            IDX_W'(1): w = {30'b0, c_ctrl};
            IDX_W'(2): w = {c_begin, c_insert};
            IDX_W'(3): w = {16'b0, c_init};
            default:   w = 32'h0;
         endcase
      end
      return w;
   endfunction

   assign idx_d       = idx_q + IDX_W'(1);
   assign in_data     = (state_q == ST_DATA);
   assign txd_last_hs = in_data && s_axis_txd_tvalid && m_axis_txd_tready && s_axis_txd_tlast;

   // Frame sequencing: control beats first, then the data pass-through window
   always_ff @(posedge aclk) begin
      if (areset) begin
         state_q       <= ST_IDLE;
         idx_q         <= '0;
         csum_ctrl_q   <= '0;
         csum_begin_q  <= '0;
         csum_insert_q <= '0;
         csum_init_q   <= '0;
         txc_valid_q   <= 1'b0;
         txc_last_q    <= 1'b0;
         txc_data_q    <= '0;
         frame_cnt_q   <= '0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (enable && s_axis_txd_tvalid) begin
                  state_q       <= ST_CTRL;
                  idx_q         <= '0;
                  csum_ctrl_q   <= cfg_csum_ctrl;
                  csum_begin_q  <= cfg_csum_begin;
                  csum_insert_q <= cfg_csum_insert;
                  csum_init_q   <= cfg_csum_init;
                  txc_valid_q   <= 1'b1;
                  txc_last_q    <= (LAST_IDX == 0);
                  txc_data_q    <= WORD0;
               end
            end
            ST_CTRL: begin
               if (m_axis_txc_tready) begin
                  if (idx_q == IDX_W'(LAST_IDX)) begin
                     state_q     <= ST_DATA;
                     idx_q       <= '0;
                     txc_valid_q <= 1'b0;
                     txc_last_q  <= 1'b0;
                     txc_data_q  <= '0;
                  end else begin
                     idx_q      <= idx_d;
                     txc_last_q <= (idx_d == IDX_W'(LAST_IDX));
                     txc_data_q <= ctrl_word(idx_d, csum_ctrl_q, csum_begin_q,
                                             csum_insert_q, csum_init_q);
                  end
               end
            end
            ST_DATA: begin
               if (txd_last_hs) begin
                  state_q     <= ST_IDLE;
                  frame_cnt_q <= frame_cnt_q + C_CNT_WIDTH'(1);
               end
            end
            default: state_q <= ST_IDLE;
         endcase
      end
   end

   // Status capture: every beat is accepted, only tlast beats are recorded
   always_ff @(posedge aclk) begin
      if (areset) begin
         status_cnt_q  <= '0;
         status_last_q <= '0;
      end else if (s_axis_txs_tvalid && s_axis_txs_tlast) begin
         status_cnt_q  <= status_cnt_q + C_CNT_WIDTH'(1);
         status_last_q <= s_axis_txs_tdata;
      end
   end

   assign m_axis_txc_tvalid = txc_valid_q;
   assign m_axis_txc_tdata  = txc_data_q;
   assign m_axis_txc_tlast  = txc_last_q;
   assign m_axis_txc_tkeep  = 4'hF;

   assign m_axis_txd_tvalid = in_data && s_axis_txd_tvalid;
   assign s_axis_txd_tready = in_data && m_axis_txd_tready;
   assign m_axis_txd_tdata  = s_axis_txd_tdata;
   assign m_axis_txd_tkeep  = s_axis_txd_tkeep;
   assign m_axis_txd_tlast  = s_axis_txd_tlast;

   assign s_axis_txs_tready = 1'b1;
   assign unused_txs_keep   = ^s_axis_txs_tkeep;

   assign frame_cnt   = frame_cnt_q;
   assign status_cnt  = status_cnt_q;
   assign status_last = status_last_q;
   assign busy        = (state_q != ST_IDLE);

endmodule

// File: tb/tb_axi_eth_tx_ctrl_bridge.sv
// Directed + randomized bench for axi_eth_tx_ctrl_bridge against a frame-level model.
module tb_axi_eth_tx_ctrl_bridge;

   localparam int unsigned DW = 32;
   localparam int unsigned NW = 6;
   localparam int unsigned CW = 4;

   logic          aclk = 1'b0;
   logic          areset;
   logic          enable;
   logic [1:0]    cfg_csum_ctrl;
   logic [15:0]   cfg_csum_begin, cfg_csum_insert, cfg_csum_init;
   logic [DW-1:0] s_txd_tdata;
   logic [3:0]    s_txd_tkeep;
   logic          s_txd_tlast, s_txd_tvalid, s_txd_tready;
   logic [DW-1:0] m_txd_tdata;
   logic [3:0]    m_txd_tkeep;
   logic          m_txd_tlast, m_txd_tvalid, m_txd_tready;
   logic [31:0]   m_txc_tdata;
   logic [3:0]    m_txc_tkeep;
   logic          m_txc_tlast, m_txc_tvalid, m_txc_tready;
   logic [31:0]   s_txs_tdata;
   logic [3:0]    s_txs_tkeep;
   logic          s_txs_tlast, s_txs_tvalid, s_txs_tready;
   logic [CW-1:0] frame_cnt, status_cnt;
   logic [31:0]   status_last;
   logic          busy;

   int vectors = 0;
   int errs    = 0;
   int exp_fcnt = 0;
   int exp_scnt = 0;
   logic [31:0] exp_slast = 32'h0;

   always #5 aclk = ~aclk;

   axi_eth_tx_ctrl_bridge #(
      .C_TDATA_WIDTH(DW), .C_CTRL_WORDS(NW), .C_CSUM_EN(1), .C_CNT_WIDTH(CW)
   ) u_dut (
      .aclk(aclk), .areset(areset), .enable(enable),
      .cfg_csum_ctrl(cfg_csum_ctrl), .cfg_csum_begin(cfg_csum_begin),
      .cfg_csum_insert(cfg_csum_insert), .cfg_csum_init(cfg_csum_init),
      .s_axis_txd_tdata(s_txd_tdata), .s_axis_txd_tkeep(s_txd_tkeep),
      .s_axis_txd_tlast(s_txd_tlast), .s_axis_txd_tvalid(s_txd_tvalid),
      .s_axis_txd_tready(s_txd_tready),
      .m_axis_txd_tdata(m_txd_tdata), .m_axis_txd_tkeep(m_txd_tkeep),
      .m_axis_txd_tlast(m_txd_tlast), .m_axis_txd_tvalid(m_txd_tvalid),
      .m_axis_txd_tready(m_txd_tready),
      .m_axis_txc_tdata(m_txc_tdata), .m_axis_txc_tkeep(m_txc_tkeep),
      .m_axis_txc_tlast(m_txc_tlast), .m_axis_txc_tvalid(m_txc_tvalid),
      .m_axis_txc_tready(m_txc_tready),
      .s_axis_txs_tdata(s_txs_tdata), .s_axis_txs_tkeep(s_txs_tkeep),
      .s_axis_txs_tlast(s_txs_tlast), .s_axis_txs_tvalid(s_txs_tvalid),
      .s_axis_txs_tready(s_txs_tready),
      .frame_cnt(frame_cnt), .status_cnt(status_cnt), .status_last(status_last),
      .busy(busy)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         errs++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge aclk);
      #1;
   endtask

   function automatic logic ready_pat(input int mode, input int cyc);
      case (mode)
         0:       return 1'b1;
         1:       return (cyc % 2) == 0;
         default: return 1'($urandom_range(0, 1));
      endcase
   endfunction

   task automatic check_counters(input string tag);
      check({tag, "_frame_cnt"},   32'(frame_cnt),  32'(exp_fcnt % (1 << CW)));
      check({tag, "_status_cnt"},  32'(status_cnt), 32'(exp_scnt % (1 << CW)));
      check({tag, "_status_last"}, status_last,     exp_slast);
   endtask

   // Drive one frame and score every txc/txd handshake; abort>=0 stops after that many data beats
   task automatic send_frame(input string tag, input int nbeats, input int txc_mode,
                             input int txd_mode, input bit fixed, input bit chk_cycles,
                             input int abort);
      logic [31:0] data[$];
      logic [3:0]  keep[$];
      logic [31:0] exp_w[NW];
      logic [31:0] held;
      bit          stall;
      int          ci, di, cyc;
      for (int b = 0; b < nbeats; b++) begin
         data.push_back(fixed ? 32'((b + 1) * 32'h11) : $urandom);
         keep.push_back(fixed ? 4'hF : 4'($urandom_range(1, 15)));
      end
      for (int w = 0; w < NW; w++) exp_w[w] = 32'h0;
      exp_w[0] = 32'hA000_0000;
      exp_w[1] = {30'b0, cfg_csum_ctrl};
      exp_w[2] = {cfg_csum_begin, cfg_csum_insert};
      exp_w[3] = {16'b0, cfg_csum_init};
      ci = 0; di = 0; cyc = 0; stall = 1'b0; held = '0;
      while (di < nbeats && cyc < 300) begin
         if (abort >= 0 && di == abort) break;
         enable       = 1'b1;
         s_txd_tvalid = 1'b1;
         s_txd_tdata  = data[di];
         s_txd_tkeep  = keep[di];
         s_txd_tlast  = (di == nbeats - 1);
         m_txc_tready = ready_pat(txc_mode, cyc);
         m_txd_tready = ready_pat(txd_mode, cyc);
         s_txs_tvalid = 1'($urandom_range(0, 1));
         s_txs_tlast  = 1'($urandom_range(0, 1));
         s_txs_tdata  = $urandom;
         if (cyc == 1) begin
            cfg_csum_ctrl   = 2'($urandom);
            cfg_csum_begin  = 16'($urandom);
            cfg_csum_insert = 16'($urandom);
            cfg_csum_init   = 16'($urandom);
         end
         #1;
         if (cyc == 0) check({tag, "_idle_busy"}, 32'(busy), 32'd0);
         if (stall) check({tag, "_txc_stable"}, {m_txc_tvalid, m_txc_tdata[30:0]},
                          {1'b1, held[30:0]});
         stall = 1'b0;
         if (m_txc_tvalid) begin
            check({tag, "_txc_keep"}, 32'(m_txc_tkeep), 32'hF);
            check({tag, "_txd_ready_in_ctrl"}, 32'(s_txd_tready), 32'd0);
            if (m_txc_tready) begin
               check({tag, "_txc_word"}, m_txc_tdata, (ci < NW) ? exp_w[ci] : 32'hDEAD_BEEF);
               check({tag, "_txc_last"}, 32'(m_txc_tlast), 32'(ci == NW - 1));
               ci++;
            end else begin
               stall = 1'b1;
               held  = m_txc_tdata;
            end
         end
         if (m_txd_tvalid && m_txd_tready) begin
            check({tag, "_ctrl_done_first"}, 32'(ci), 32'(NW));
            check({tag, "_txd_ready"}, 32'(s_txd_tready), 32'd1);
            check({tag, "_txd_data"}, m_txd_tdata, data[di]);
            check({tag, "_txd_keep"}, 32'(m_txd_tkeep), 32'(keep[di]));
            check({tag, "_txd_last"}, 32'(m_txd_tlast), 32'(di == nbeats - 1));
            if (di == nbeats - 1) exp_fcnt++;
            di++;
         end
         check({tag, "_txs_ready"}, 32'(s_txs_tready), 32'd1);
         if (s_txs_tvalid && s_txs_tlast) begin
            exp_scnt++;
            exp_slast = s_txs_tdata;
         end
         step();
         cyc++;
      end
      s_txd_tvalid = 1'b0;
      s_txs_tvalid = 1'b0;
      if (abort < 0) begin
         check({tag, "_frame_done"}, 32'(di), 32'(nbeats));
         if (chk_cycles) check({tag, "_cycles"}, 32'(cyc), 32'(1 + NW + nbeats));
         check_counters(tag);
      end
   endtask

   task automatic do_reset();
      areset       = 1'b1;
      enable       = 1'b0;
      s_txs_tvalid = 1'b0;
      step();
      areset = 1'b0;
      exp_fcnt  = 0;
      exp_scnt  = 0;
      exp_slast = 32'h0;
   endtask

   initial begin
      areset = 1'b1; enable = 1'b0;
      cfg_csum_ctrl = '0; cfg_csum_begin = '0; cfg_csum_insert = '0; cfg_csum_init = '0;
      s_txd_tdata = '0; s_txd_tkeep = '0; s_txd_tlast = 1'b0; s_txd_tvalid = 1'b0;
      m_txd_tready = 1'b0; m_txc_tready = 1'b0;
      s_txs_tdata = '0; s_txs_tkeep = 4'hF; s_txs_tlast = 1'b0; s_txs_tvalid = 1'b0;
      step(); step();
      areset = 1'b0;

      // Reset state
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_txc_valid", 32'(m_txc_tvalid), 32'd0);
      check("rst_txd_valid", 32'(m_txd_tvalid), 32'd0);
      check("rst_txd_ready", 32'(s_txd_tready), 32'd0);
      check("rst_txs_ready", 32'(s_txs_tready), 32'd1);
      check_counters("rst");

      // Zero cfg, 4-beat fixed frame, readies high, cycle count
      send_frame("t1", 4, 0, 0, 1'b1, 1'b1, -1);

      // Checksum words from a known cfg
      cfg_csum_ctrl = 2'd2; cfg_csum_begin = 16'h000E;
      cfg_csum_insert = 16'h0028; cfg_csum_init = 16'hFFFF;
      send_frame("t2", 3, 0, 0, 1'b0, 1'b1, -1);

      // Toggling txc backpressure
      send_frame("t3", 5, 1, 0, 1'b0, 1'b0, -1);

      // Back-to-back single-beat frames
      send_frame("t4a", 1, 0, 0, 1'b0, 1'b1, -1);
      send_frame("t4b", 1, 0, 0, 1'b0, 1'b1, -1);

      // enable low holds the next frame in IDLE
      enable = 1'b0; s_txd_tvalid = 1'b1; m_txc_tready = 1'b1;
      for (int i = 0; i < 3; i++) begin
         step();
         check("en_low_busy", 32'(busy), 32'd0);
         check("en_low_txc_valid", 32'(m_txc_tvalid), 32'd0);
      end
      s_txd_tvalid = 1'b0;

      // Random frames with random backpressure on both sides
      for (int f = 0; f < 12; f++)
         send_frame("rnd", int'($urandom_range(1, 8)), 2, 2, 1'b0, 1'b0, -1);

      // Reset in DATA after 2 of 5 beats
      send_frame("t5", 5, 0, 0, 1'b0, 1'b0, 2);
      s_txd_tvalid = 1'b1;
      do_reset();
      check("t5_busy", 32'(busy), 32'd0);
      check("t5_txc_valid", 32'(m_txc_tvalid), 32'd0);
      check("t5_txd_valid", 32'(m_txd_tvalid), 32'd0);
      check("t5_txd_ready", 32'(s_txd_tready), 32'd0);
      check_counters("t5");
      send_frame("t5_next", 2, 0, 0, 1'b0, 1'b1, -1);

      // Status counter wrap with CW=4
      do_reset();
      for (int i = 0; i < 16; i++) begin
         s_txs_tvalid = 1'b1; s_txs_tlast = 1'b0; s_txs_tdata = $urandom;
         step();
         s_txs_tlast = 1'b1;
         s_txs_tdata = (i == 15) ? 32'h0000_00AB : $urandom;
         exp_scnt++;
         exp_slast = s_txs_tdata;
         step();
      end
      s_txs_tvalid = 1'b0;
      check("t6_status_cnt", 32'(status_cnt), 32'd0);
      check("t6_status_last", status_last, 32'h0000_00AB);
      check_counters("t6");

      $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
      $finish;
   end

endmodule
